cache_control: RTL and testbench

Control FSM for the 2-way set-associative L1 cache used by the pipelined RISC-V core. It sits directly upstream of the cache's metadata and data arrays. It reads their combinational outputs (valid, dirty, tag, LRU), detects hit or miss, and drives their load strobes and write indices. It also sequences victim writeback and line refill over the physical-memory port, which is the cacheline adaptor.

---
 rtl/cache_types.sv | 20 ++
 rtl/cache_control_if.sv | 49 ++++
 rtl/cache_hit_detect.sv | 20 ++
 rtl/cache_control.sv | 102 ++++++++++
 tb/tb_cache_control.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_types.sv
// Shared types for the L1 cache controller: FSM states and mux-select encodings.
package cache_types;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   typedef enum logic {
      DATA_SRC_CPU  = 1'b0,
      DATA_SRC_PMEM = 1'b1
   } data_src_e;

   typedef enum logic {
      TAG_SEL_ADDR   = 1'b0,
      TAG_SEL_VICTIM = 1'b1
   } pmem_tag_sel_e;

endpackage

// File: rtl/cache_control_if.sv
// Bus bundle between the cache controller, the CPU request side, the metadata/data
// arrays and the cacheline adaptor.
interface cache_control_if #(
   parameter int unsigned s_index = 3,
   parameter int unsigned s_tag   = 24
);
   logic               mem_read;
   logic               mem_write;
   logic [s_tag-1:0]   addr_tag;
   logic [s_index-1:0] addr_index;
   logic [1:0]         valid;
   logic [1:0]         dirty;
   logic [s_tag-1:0]   tag0;
   logic [s_tag-1:0]   tag1;
   logic               lru;
   logic               pmem_resp;

   logic               mem_resp;
   logic               pmem_read;
   logic               pmem_write;
   logic               pmem_tag_sel;
   logic               way_sel;
   logic [1:0]         load_data;
   logic               data_src;
   logic [1:0]         load_tag;
   logic [1:0]         load_valid;
   logic [1:0]         load_dirty;
   logic               dirty_in;
   logic               valid_in;
   logic               load_lru;
   logic               lru_in;
   logic [s_index-1:0] windex;

   // Environment side: CPU, arrays and memory adaptor.
   modport master (
      output mem_read, mem_write, addr_tag, addr_index, valid, dirty, tag0, tag1, lru,
             pmem_resp,
      input  mem_resp, pmem_read, pmem_write, pmem_tag_sel, way_sel, load_data, data_src,
             load_tag, load_valid, load_dirty, dirty_in, valid_in, load_lru, lru_in, windex
   );

   // Controller side.
   modport slave (
      input  mem_read, mem_write, addr_tag, addr_index, valid, dirty, tag0, tag1, lru,
             pmem_resp,
      output mem_resp, pmem_read, pmem_write, pmem_tag_sel, way_sel, load_data, data_src,
             load_tag, load_valid, load_dirty, dirty_in, valid_in, load_lru, lru_in, windex
   );
endinterface

// File: rtl/cache_hit_detect.sv
// Two-way tag compare; way 0 takes priority when both ways match.
module cache_hit_detect #(
   parameter int unsigned s_tag = 24
) (
   input  logic [1:0]       valid_i,
   input  logic [s_tag-1:0] tag0_i,
   input  logic [s_tag-1:0] tag1_i,
   input  logic [s_tag-1:0] addr_tag_i,
   output logic             hit_o,
   output logic             hit_way_o
);
   logic [1:0] hit;

   always_comb begin
      hit[0]    = valid_i[0] & (tag0_i == addr_tag_i);
      hit[1]    = valid_i[1] & (tag1_i == addr_tag_i);
      hit_o     = |hit;
      hit_way_o = hit[1] & ~hit[0];
   end
endmodule

// File: rtl/cache_control.sv
// Hit/miss control FSM for the 2-way L1: serves hits in COMPARE, sequences victim
// writeback and line refill over the pmem port on a miss.
module cache_control
   import cache_types::*;
#(
   parameter int unsigned s_index = 3,
   parameter int unsigned s_tag   = 24
) (
   input logic            clk,
   input logic            rst,
   cache_control_if.slave bus
);
   state_e             state_q, state_d;
   logic               hit;
   logic               hit_way;
   logic               victim;
   logic [s_index-1:0] set_idx;

   cache_hit_detect #(
      .s_tag(s_tag)
   ) u_hit_detect (
      .valid_i   (bus.valid),
      .tag0_i    (bus.tag0),
      .tag1_i    (bus.tag1),
      .addr_tag_i(bus.addr_tag),
      .hit_o     (hit),
      .hit_way_o (hit_way)
   );

   assign set_idx = bus.addr_index;

   always_ff @(posedge clk) begin
      if (rst) state_q <= COMPARE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d          = state_q;
      // lru is never written mid-miss, so the victim is stable across the miss.
      victim           = bus.lru;
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_tag_sel = TAG_SEL_ADDR;
      bus.way_sel      = 1'b0;
      bus.load_data    = 2'b00;
      bus.data_src     = DATA_SRC_CPU;
      bus.load_tag     = 2'b00;
      bus.load_valid   = 2'b00;
      bus.load_dirty   = 2'b00;
      bus.dirty_in     = 1'b0;
      bus.valid_in     = 1'b0;
      bus.load_lru     = 1'b0;
      bus.lru_in       = 1'b0;
      bus.windex       = set_idx;

      unique case (state_q)
         COMPARE: begin
            if (bus.mem_read || bus.mem_write) begin
               if (hit) begin
                  bus.mem_resp = 1'b1;
                  bus.way_sel  = hit_way;
                  bus.load_lru = 1'b1;
                  bus.lru_in   = ~hit_way;
                  // A simultaneous read and write is served as a write.
                  if (bus.mem_write) begin
                     bus.load_data[hit_way]  = 1'b1;
                     bus.data_src            = DATA_SRC_CPU;
                     bus.load_dirty[hit_way] = 1'b1;
                     bus.dirty_in            = 1'b1;
                  end
               end else if (bus.dirty[victim]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_tag_sel = TAG_SEL_VICTIM;
            bus.way_sel      = victim;
            if (bus.pmem_resp) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_tag_sel = TAG_SEL_ADDR;
            if (bus.pmem_resp) begin
               bus.load_data[victim]  = 1'b1;
               bus.data_src           = DATA_SRC_PMEM;
               bus.load_tag[victim]   = 1'b1;
               bus.load_valid[victim] = 1'b1;
               bus.valid_in           = 1'b1;
               bus.load_dirty[victim] = 1'b1;
               bus.dirty_in           = 1'b0;
               state_d                = COMPARE;
            end
         end
         default: state_d = COMPARE;
      endcase
   end
endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: stimulus pushes the expected per-cycle output
// vector into a scoreboard queue, a negedge monitor pops and compares it.
module tb_cache_control;

   typedef struct packed {
      logic       mem_resp;
      logic       pmem_read;
      logic       pmem_write;
      logic       pmem_tag_sel;
      logic       way_sel;
      logic [1:0] load_data;
      logic       data_src;
      logic [1:0] load_tag;
      logic [1:0] load_valid;
      logic [1:0] load_dirty;
      logic       dirty_in;
      logic       valid_in;
      logic       load_lru;
      logic       lru_in;
      logic [2:0] windex;
   } exp_t;

   typedef struct {
      string nm;
      exp_t  e;
   } sb_item_t;

   logic     clk = 1'b0;
   logic     rst;
   int       checks   = 0;
   int       failures = 0;
   sb_item_t sb_q[$];

   cache_control_if #(.s_index(3), .s_tag(24)) bus ();

   cache_control #(
      .s_index(3),
      .s_tag  (24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t base(input logic [2:0] idx);
      exp_t e;
      e        = '0;
      e.windex = idx;
      return e;
   endfunction

   function automatic exp_t hit_e(input logic [2:0] idx, input logic way, input logic wr);
      exp_t e;
      e          = base(idx);
      e.mem_resp = 1'b1;
      e.way_sel  = way;
      e.load_lru = 1'b1;
      e.lru_in   = ~way;
      if (wr) begin
         e.load_data[way]  = 1'b1;
         e.load_dirty[way] = 1'b1;
         e.dirty_in        = 1'b1;
      end
      return e;
   endfunction

   function automatic exp_t wb_e(input logic [2:0] idx, input logic way);
      exp_t e;
      e              = base(idx);
      e.pmem_write   = 1'b1;
      e.pmem_tag_sel = 1'b1;
      e.way_sel      = way;
      return e;
   endfunction

   function automatic exp_t alloc_e(input logic [2:0] idx);
      exp_t e;
      e           = base(idx);
      e.pmem_read = 1'b1;
      return e;
   endfunction

   function automatic exp_t refill_e(input logic [2:0] idx, input logic way);
      exp_t e;
      e                 = alloc_e(idx);
      e.load_data[way]  = 1'b1;
      e.data_src        = 1'b1;
      e.load_tag[way]   = 1'b1;
      e.load_valid[way] = 1'b1;
      e.valid_in        = 1'b1;
      e.load_dirty[way] = 1'b1;
      e.dirty_in        = 1'b0;
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input exp_t e);
      sb_item_t it;
      it.nm = nm;
      it.e  = e;
      sb_q.push_back(it);
   endtask

   // Monitor: every cycle that has a pending expectation is compared mid-cycle.
   initial begin
      sb_item_t it;
      exp_t     act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = '{bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_tag_sel,
                    bus.way_sel, bus.load_data, bus.data_src, bus.load_tag, bus.load_valid,
                    bus.load_dirty, bus.dirty_in, bus.valid_in, bus.load_lru, bus.lru_in,
                    bus.windex};
            checks++;
            if (act !== it.e) begin
               failures++;
               $display("FAIL %s: got %b required %b", it.nm, act, it.e);
            end
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.addr_tag   = '0;
      bus.addr_index = 3'd5;
      bus.valid      = 2'b00;
      bus.dirty      = 2'b00;
      bus.tag0       = '0;
      bus.tag1       = '0;
      bus.lru        = 1'b0;
      bus.pmem_resp  = 1'b0;
      cyc();
      cyc();
      expect_out("reset_idle", base(3'd5));
      cyc();
      rst = 1'b0;

      // Cold read miss, clean victim way 0, refill after 3 ALLOCATE cycles.
      cyc();
      bus.addr_tag = 24'h123456;
      bus.mem_read = 1'b1;
      expect_out("cold_miss", base(3'd5));
      cyc(); expect_out("cold_alloc0", alloc_e(3'd5));
      cyc(); expect_out("cold_alloc1", alloc_e(3'd5));
      cyc(); bus.pmem_resp = 1'b1; expect_out("cold_refill", refill_e(3'd5, 1'b0));
      cyc();
      bus.pmem_resp = 1'b0;
      bus.valid     = 2'b01;
      bus.tag0      = 24'h123456;
      expect_out("cold_hit", hit_e(3'd5, 1'b0, 1'b0));
      cyc(); bus.mem_read = 1'b0; bus.lru = 1'b1; expect_out("idle_a", base(3'd5));

      // Read hit in way 1.
      cyc();
      bus.tag1     = 24'hABCDEF;
      bus.valid    = 2'b10;
      bus.addr_tag = 24'hABCDEF;
      bus.mem_read = 1'b1;
      expect_out("rd_hit_w1", hit_e(3'd5, 1'b1, 1'b0));
      cyc(); bus.mem_read = 1'b0; bus.lru = 1'b0; expect_out("idle_b", base(3'd5));

      // Write hit in way 0.
      cyc();
      bus.valid     = 2'b11;
      bus.tag0      = 24'h111111;
      bus.addr_tag  = 24'h111111;
      bus.mem_write = 1'b1;
      expect_out("wr_hit_w0", hit_e(3'd5, 1'b0, 1'b1));
      cyc(); bus.mem_write = 1'b0; expect_out("idle_c", base(3'd5));

      // Both ways match: way 0 wins.
      cyc(); bus.tag1 = 24'h111111; bus.mem_read = 1'b1;
      expect_out("dbl_hit", hit_e(3'd5, 1'b0, 1'b0));
      cyc(); bus.mem_read = 1'b0; expect_out("idle_d", base(3'd5));

      // Dirty miss with victim way 1.
      cyc();
      bus.lru      = 1'b1;
      bus.dirty    = 2'b10;
      bus.tag1     = 24'hABCDEF;
      bus.addr_tag = 24'h222222;
      bus.mem_read = 1'b1;
      expect_out("dm_miss", base(3'd5));
      cyc(); expect_out("dm_wb0", wb_e(3'd5, 1'b1));
      cyc(); bus.pmem_resp = 1'b1; expect_out("dm_wb_resp", wb_e(3'd5, 1'b1));
      cyc(); bus.pmem_resp = 1'b0; expect_out("dm_alloc0", alloc_e(3'd5));
      cyc(); bus.pmem_resp = 1'b1; expect_out("dm_refill", refill_e(3'd5, 1'b1));
      cyc();
      bus.pmem_resp = 1'b0;
      bus.tag1      = 24'h222222;
      bus.dirty     = 2'b00;
      expect_out("dm_hit", hit_e(3'd5, 1'b1, 1'b0));
      cyc(); bus.mem_read = 1'b0; bus.lru = 1'b0; expect_out("idle_e", base(3'd5));

      // Stray pmem_resp in COMPARE.
      cyc(); bus.pmem_resp = 1'b1; expect_out("stray_resp", base(3'd5));
      cyc(); bus.pmem_resp = 1'b0; expect_out("stray_after", base(3'd5));

      // Reset mid-ALLOCATE, then the held request replays the miss.
      cyc();
      bus.addr_index = 3'd2;
      bus.valid      = 2'b00;
      bus.addr_tag   = 24'h333333;
      bus.mem_read   = 1'b1;
      expect_out("rst_miss", base(3'd2));
      cyc(); expect_out("rst_alloc", alloc_e(3'd2));
      cyc(); rst = 1'b1; expect_out("rst_alloc_in_rst", alloc_e(3'd2));
      cyc(); rst = 1'b0; expect_out("rst_after", base(3'd2));
      cyc(); expect_out("rst_replay_alloc", alloc_e(3'd2));
      cyc(); bus.pmem_resp = 1'b1; expect_out("rst_replay_refill", refill_e(3'd2, 1'b0));
      cyc();
      bus.pmem_resp = 1'b0;
      bus.valid     = 2'b01;
      bus.tag0      = 24'h333333;
      expect_out("rst_replay_hit", hit_e(3'd2, 1'b0, 1'b0));
      cyc(); bus.mem_read = 1'b0; expect_out("idle_f", base(3'd2));

      // Read and write together on a way-1 hit: write path.
      cyc();
      bus.addr_index = 3'd5;
      bus.valid      = 2'b10;
      bus.tag1       = 24'h444444;
      bus.addr_tag   = 24'h444444;
      bus.mem_read   = 1'b1;
      bus.mem_write  = 1'b1;
      expect_out("rdwr_hit_w1", hit_e(3'd5, 1'b1, 1'b1));
      cyc(); bus.mem_read = 1'b0; bus.mem_write = 1'b0; expect_out("idle_g", base(3'd5));

      cyc();
      cyc();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
